// File: rtl/wb_master_if.sv
// rtl/wb_master_if.sv - command/response handshake and Wishbone control signals for wb_master
interface wb_master_if;
    logic        i_cmd_valid;
    logic        o_cmd_ready;
    logic        i_cmd_we;
    logic [31:0] i_cmd_addr;
    logic [31:0] i_cmd_wdata;
    logic        o_rsp_valid;
    logic [31:0] o_rsp_rdata;
    logic        o_rsp_err;
    logic        o_wb_cyc;
    logic        o_wb_stb;
    logic        o_wb_we;
    logic [31:0] o_wb_addr;
    logic        i_wb_ack;

    modport master (
        input  i_cmd_valid, i_cmd_we, i_cmd_addr, i_cmd_wdata, i_wb_ack,
        output o_cmd_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err,
        output o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr
    );

    modport slave (
        output i_cmd_valid, i_cmd_we, i_cmd_addr, i_cmd_wdata, i_wb_ack,
        input  o_cmd_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err,
        input  o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr
    );
endinterface

// File: rtl/wb_master.sv
// rtl/wb_master.sv - Wishbone classic initiator, one bus cycle per command with ack timeout
module wb_master #(
    parameter int TIMEOUT = 16,
    parameter int TO_W    = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1)
) (
    input  logic        clk,
    input  logic        rst,
    wb_master_if.master bus,
    inout  wire  [31:0] io_wb_data
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        STB  = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_t          state_q, state_d;
    logic            we_q, we_d;
    logic [31:0]     addr_q, addr_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [31:0]     rdata_q, rdata_d;
    logic            err_q, err_d;
    logic [TO_W-1:0] cnt_q, cnt_d;
    logic            cyc_q, stb_q, wb_we_q, rsp_valid_q, ready_q;

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (bus.i_cmd_valid) begin
                    we_d    = bus.i_cmd_we;
                    addr_d  = bus.i_cmd_addr;
                    wdata_d = bus.i_cmd_wdata;
                    cnt_d   = '0;
                    state_d = STB;
                end
            end
            STB: begin
                // ack wins over a timeout expiring on the same edge
                if (bus.i_wb_ack) begin
                    rdata_d = we_q ? 32'd0 : io_wb_data;
                    err_d   = 1'b0;
                    state_d = HOLD;
                end else if ((TIMEOUT != 0) && (cnt_q == TO_LAST)) begin
                    rdata_d = 32'd0;
                    err_d   = 1'b1;
                    state_d = HOLD;
                end else if (cnt_q != {TO_W{1'b1}}) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HOLD: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Bus outputs are registered from the next state so they line up with state_q
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            we_q        <= 1'b0;
            addr_q      <= 32'd0;
            wdata_q     <= 32'd0;
            rdata_q     <= 32'd0;
            err_q       <= 1'b0;
            cnt_q       <= '0;
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
            wb_we_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            ready_q     <= 1'b1;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
            cnt_q       <= cnt_d;
            cyc_q       <= (state_d != IDLE);
            stb_q       <= (state_d == STB);
            wb_we_q     <= (state_d == STB) && we_d;
            rsp_valid_q <= (state_d == HOLD);
            ready_q     <= (state_d == IDLE);
        end
    end

    // The data bus is driven only while a write strobe is on the bus
    assign io_wb_data      = wb_we_q ? wdata_q : 32'hz;

    assign bus.o_cmd_ready = ready_q;
    assign bus.o_rsp_valid = rsp_valid_q;
    assign bus.o_rsp_rdata = rdata_q;
    assign bus.o_rsp_err   = err_q;
    assign bus.o_wb_cyc    = cyc_q;
    assign bus.o_wb_stb    = stb_q;
    assign bus.o_wb_we     = wb_we_q;
    assign bus.o_wb_addr   = addr_q;
endmodule

// File: tb/tb_wb_master.sv
// tb/tb_wb_master.sv - self-checking bench for wb_master with a behavioural memory slave
module tb_wb_master;
    localparam int TIMEOUT = 16;
    localparam int ACK_LAT = 3;
    localparam int TO_LAT  = TIMEOUT + 1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    wb_master_if wbi ();
    wire [31:0] bus_data;

    wb_master #(.TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (wbi),
        .io_wb_data (bus_data)
    );

    // Undriven bus reads back as all ones
    pullup (bus_data);

    function automatic logic [31:0] dflt(input int a);
        if (a == 0) return 32'd1;
        if (a == 1) return 32'd262144;
        return 32'(a * 10);
    endfunction

    // Slave: 64 words, registered ack while strobed, no ack outside its range
    logic [31:0] smem [64];
    bit          smem_init = 1'b0;
    logic        ack_auto;
    logic        ack_man = 1'b0;
    int          slv_mode = 0;
    logic        slv_hit;

    assign slv_hit      = (wbi.o_wb_addr < 32'd64);
    assign wbi.i_wb_ack = (slv_mode == 0) ? ack_auto : (slv_mode == 2) ? ack_man : 1'b0;
    assign bus_data     = (wbi.o_wb_stb && !wbi.o_wb_we && slv_hit) ? smem[wbi.o_wb_addr[5:0]] : 32'hz;

    always @(posedge clk or negedge rst) begin
        if (!rst) ack_auto <= 1'b0;
        else      ack_auto <= wbi.o_wb_cyc && wbi.o_wb_stb && slv_hit;
    end

    always @(posedge clk) begin
        if (!smem_init) begin
            for (int i = 0; i < 64; i++) smem[i] <= dflt(i);
            smem_init <= 1'b1;
        end else if (rst && wbi.o_wb_cyc && wbi.o_wb_stb && wbi.o_wb_we && wbi.i_wb_ack && slv_hit) begin
            smem[wbi.o_wb_addr[5:0]] <= bus_data;
        end
    end

    logic [31:0] cur_wdata = 32'd0;
    int          rsp_cnt   = 0;
    int          bus_viol  = 0;

    always @(negedge clk) begin
        if (rst) begin
            if (wbi.o_rsp_valid) rsp_cnt <= rsp_cnt + 1;
            if (wbi.o_wb_stb && wbi.o_wb_we) begin
                if (bus_data !== cur_wdata) bus_viol <= bus_viol + 1;
            end else if (wbi.o_wb_stb && slv_hit) begin
                if (bus_data !== smem[wbi.o_wb_addr[5:0]]) bus_viol <= bus_viol + 1;
            end else if (bus_data !== 32'hFFFF_FFFF) begin
                bus_viol <= bus_viol + 1;
            end
        end
    end

    int nchk = 0;
    int nerr = 0;
    logic [31:0] ref_mem [64];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic do_cmd(input logic we, input logic [31:0] a, input logic [31:0] wd,
                          output logic [31:0] rd, output logic er, output int lat);
        int n = 0;
        rd  = 32'd0;
        er  = 1'b0;
        lat = -1;
        while (!wbi.o_cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        cur_wdata       = wd;
        wbi.i_cmd_we    = we;
        wbi.i_cmd_addr  = a;
        wbi.i_cmd_wdata = wd;
        wbi.i_cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        wbi.i_cmd_valid = 1'b0;
        wbi.i_cmd_we    = ~we;
        wbi.i_cmd_addr  = $urandom;
        wbi.i_cmd_wdata = $urandom;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (wbi.o_rsp_valid) begin
                rd  = wbi.o_rsp_rdata;
                er  = wbi.o_rsp_err;
                lat = c;
                break;
            end
        end
    endtask

    task automatic run_vec(input string nm, input logic we, input logic [31:0] a, input logic [31:0] wd,
                           input logic [31:0] exp_rd, input logic exp_er, input int exp_lat);
        logic [31:0] rd;
        logic        er;
        int          lat;
        do_cmd(we, a, wd, rd, er, lat);
        chk({nm, ".latency"}, lat, exp_lat);
        chk({nm, ".rdata"}, rd, exp_rd);
        chk({nm, ".err"}, er, exp_er);
        @(negedge clk);
        chk({nm, ".rsp_one_cycle"}, wbi.o_rsp_valid, 1'b0);
        chk({nm, ".cyc_low_after"}, wbi.o_wb_cyc, 1'b0);
        chk({nm, ".ready_after"}, wbi.o_cmd_ready, 1'b1);
    endtask

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    vec_t        vecs [7];
    int          b2b_a [3];
    int          acc [3];
    int          nacc, nrsp, base_rsp, early;
    logic        rdy, r_we, r_err;
    logic [31:0] r_a, r_wd, r_rd;
    int          r_lat;

    initial begin
        for (int i = 0; i < 64; i++) ref_mem[i] = dflt(i);
        wbi.i_cmd_valid = 1'b0;
        wbi.i_cmd_we    = 1'b0;
        wbi.i_cmd_addr  = 32'd0;
        wbi.i_cmd_wdata = 32'd0;

        @(posedge clk);
        #1;
        chk("reset.cyc", wbi.o_wb_cyc, 1'b0);
        chk("reset.stb", wbi.o_wb_stb, 1'b0);
        chk("reset.we", wbi.o_wb_we, 1'b0);
        chk("reset.rsp_valid", wbi.o_rsp_valid, 1'b0);
        chk("reset.rsp_err", wbi.o_rsp_err, 1'b0);
        chk("reset.addr", wbi.o_wb_addr, 32'd0);
        chk("reset.rdata", wbi.o_rsp_rdata, 32'd0);
        chk("reset.bus_released", bus_data, 32'hFFFF_FFFF);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("reset.ready", wbi.o_cmd_ready, 1'b1);

        vecs[0] = '{1'b0, 32'd0,          32'd0,          32'd1,          1'b0, ACK_LAT};
        vecs[1] = '{1'b0, 32'd1,          32'd0,          32'd262144,     1'b0, ACK_LAT};
        vecs[2] = '{1'b0, 32'd50,         32'd0,          32'd500,        1'b0, ACK_LAT};
        vecs[3] = '{1'b1, 32'd7,          32'hDEAD_BEEF,  32'd0,          1'b0, ACK_LAT};
        vecs[4] = '{1'b0, 32'd7,          32'd0,          32'hDEAD_BEEF,  1'b0, ACK_LAT};
        vecs[5] = '{1'b0, 32'h0001_0000,  32'd0,          32'd0,          1'b1, TO_LAT};
        vecs[6] = '{1'b1, 32'h0001_0004,  32'h0000_0055,  32'd0,          1'b1, TO_LAT};
        for (int i = 0; i < 7; i++) begin
            run_vec($sformatf("vec%0d", i), vecs[i].we, vecs[i].addr, vecs[i].wdata,
                    vecs[i].exp_rd, vecs[i].exp_err, vecs[i].exp_lat);
            if (vecs[i].we && vecs[i].addr < 32'd64) ref_mem[vecs[i].addr[5:0]] = vecs[i].wdata;
        end

        // Back-to-back reads with valid held high; inputs change right after each accept
        b2b_a    = '{2, 1, 50};
        base_rsp = rsp_cnt;
        nacc     = 0;
        nrsp     = 0;
        wbi.i_cmd_we    = 1'b0;
        wbi.i_cmd_addr  = 32'(b2b_a[0]);
        wbi.i_cmd_valid = 1'b1;
        for (int c = 0; c < 20; c++) begin
            rdy = wbi.o_cmd_ready;
            if (wbi.o_rsp_valid && nrsp < 3) begin
                chk("b2b.rdata", wbi.o_rsp_rdata, ref_mem[b2b_a[nrsp]]);
                nrsp++;
            end
            @(posedge clk);
            if (rdy && wbi.i_cmd_valid && nacc < 3) begin
                acc[nacc] = c;
                nacc++;
                #1;
                if (nacc < 3) wbi.i_cmd_addr = 32'(b2b_a[nacc]);
                else          wbi.i_cmd_valid = 1'b0;
            end
            @(negedge clk);
        end
        wbi.i_cmd_valid = 1'b0;
        chk("b2b.accepts", nacc, 3);
        chk("b2b.spacing01", acc[1] - acc[0], 4);
        chk("b2b.spacing12", acc[2] - acc[1], 4);
        chk("b2b.responses", nrsp, 3);
        chk("b2b.rsp_pulses", rsp_cnt - base_rsp, 3);

        // Ack arrives on the same edge the timeout would fire
        slv_mode        = 2;
        ack_man         = 1'b0;
        cur_wdata       = 32'd0;
        early           = 0;
        wbi.i_cmd_we    = 1'b0;
        wbi.i_cmd_addr  = 32'd5;
        wbi.i_cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        wbi.i_cmd_valid = 1'b0;
        for (int c = 1; c < TIMEOUT; c++) begin
            @(negedge clk);
            if (wbi.o_rsp_valid) early++;
        end
        @(negedge clk);
        ack_man = 1'b1;
        @(negedge clk);
        ack_man = 1'b0;
        chk("race.early_rsp", early, 0);
        chk("race.rsp_valid", wbi.o_rsp_valid, 1'b1);
        chk("race.err", wbi.o_rsp_err, 1'b0);
        chk("race.rdata", wbi.o_rsp_rdata, ref_mem[5]);
        @(negedge clk);
        chk("race.rsp_one_cycle", wbi.o_rsp_valid, 1'b0);
        slv_mode = 0;
        @(negedge clk);

        // Asynchronous reset in the middle of a write strobe
        cur_wdata       = 32'h1234_5678;
        wbi.i_cmd_we    = 1'b1;
        wbi.i_cmd_addr  = 32'd9;
        wbi.i_cmd_wdata = 32'h1234_5678;
        wbi.i_cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        wbi.i_cmd_valid = 1'b0;
        chk("arst.bus_driven", bus_data, 32'h1234_5678);
        #2;
        rst = 1'b0;
        #1;
        chk("arst.cyc", wbi.o_wb_cyc, 1'b0);
        chk("arst.stb", wbi.o_wb_stb, 1'b0);
        chk("arst.we", wbi.o_wb_we, 1'b0);
        chk("arst.bus_released", bus_data, 32'hFFFF_FFFF);
        chk("arst.rsp_valid", wbi.o_rsp_valid, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst      = 1'b1;
        base_rsp = rsp_cnt;
        repeat (4) @(negedge clk);
        chk("arst.no_response", rsp_cnt - base_rsp, 0);
        run_vec("arst.read9", 1'b0, 32'd9, 32'd0, ref_mem[9], 1'b0, ACK_LAT);
        run_vec("arst.read0", 1'b0, 32'd0, 32'd0, 32'd1, 1'b0, ACK_LAT);

        // Random traffic against the memory model
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 7) == 0) r_a = 32'h0001_0000 + 32'($urandom_range(0, 4095));
            else                           r_a = 32'($urandom_range(0, 63));
            r_we = 1'($urandom_range(0, 1));
            r_wd = $urandom;
            if (r_a < 32'd64) begin
                r_err = 1'b0;
                r_lat = ACK_LAT;
                if (r_we) begin
                    r_rd = 32'd0;
                    ref_mem[r_a[5:0]] = r_wd;
                end else begin
                    r_rd = ref_mem[r_a[5:0]];
                end
            end else begin
                r_rd  = 32'd0;
                r_err = 1'b1;
                r_lat = TO_LAT;
            end
            repeat ($urandom_range(0, 2)) @(negedge clk);
            run_vec($sformatf("rand%0d", i), r_we, r_a, r_wd, r_rd, r_err, r_lat);
        end

        chk("bus.ownership", bus_viol, 0);
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", nerr, nchk);
        $fatal(1);
    end
endmodule

// File: doc/wb_master.md
Name: wb_master

Overview:
- Wishbone classic initiator for the 32-bit shared-data bus used by the team's Wishbone memory slave: wb_memory-style responders, combined strobe/cycle qualifier, single ack pulse, bidirectional data bus.
- Accepts single read/write commands on a valid/ready interface, runs one bus cycle per command, and returns read data or an error on a one-cycle response strobe.
- Sits between a CPU or test sequencer and one or more Wishbone memory slaves.

Parameters:
- TIMEOUT, 16, cycles to wait for ack in the strobe phase before aborting with error; 0 disables the timeout (wait forever).
- TO_W, $clog2(TIMEOUT+1) (minimum 1), width of the timeout counter. Derived; do not override.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  reset, asynchronous assert, active-low (0 = reset).
- i_cmd_valid  input  1  command present.
- o_cmd_ready  output  1  master idle; command accepted when i_cmd_valid && o_cmd_ready at a rising edge.
- i_cmd_we  input  1  1 = write, 0 = read.
- i_cmd_addr  input  32  word address.
- i_cmd_wdata  input  32  write data (ignored for reads).
- o_rsp_valid  output  1  one-cycle response strobe.
- o_rsp_rdata  output  32  read data; 0 for writes and for errors.
- o_rsp_err  output  1  1 = timeout abort; qualified by o_rsp_valid.
- o_wb_cyc  output  1  bus cycle.
- o_wb_stb  output  1  strobe.
- o_wb_we  output  1  write enable.
- o_wb_addr  output  32  address.
- i_wb_ack  input  1  slave acknowledge.
- io_wb_data  inout  32  shared data bus.

Behaviour:
- Reset (rst=0, takes effect immediately, no clock needed):
  - FSM to IDLE.
  - o_wb_cyc, o_wb_stb, o_wb_we, o_rsp_valid and o_rsp_err = 0.
  - o_wb_addr and o_rsp_rdata = 0.
  - io_wb_data = Z.
  - Timeout counter = 0.
  - o_cmd_ready = 1 once rst releases.
  - Reset mid-transaction aborts the cycle without a response.
- All outputs are registered. o_cmd_ready equals (state==IDLE).
- FSM states: IDLE, STB, HOLD.
- IDLE:
  - cyc, stb and we = 0; io_wb_data = Z.
  - On command accept: latch we, addr and wdata; clear the counter; go to STB.
- STB:
  - cyc = 1, stb = 1, we = latched value, addr = latched value.
  - io_wb_data driven with latched wdata only when we = 1; otherwise Z.
  - On an edge with i_wb_ack = 1: capture io_wb_data into o_rsp_rdata for a read (0 for a write); err = 0; go to HOLD.
  - Otherwise, if TIMEOUT != 0 and counter == TIMEOUT-1: rdata = 0, err = 1, go to HOLD.
  - Otherwise increment the counter. The counter saturates and never wraps.
  - Ack has priority over timeout on the same edge.
- HOLD (exactly one cycle):
  - stb = 0, cyc = 1, we = 0, io_wb_data = Z.
  - o_rsp_valid = 1 with rdata/err held.
  - Next state is IDLE; o_rsp_valid returns to 0.
- Ack handling: i_wb_ack is ignored outside STB. The slave re-asserts ack in HOLD because stb was still high at the ack edge; this second ack must produce no second response.
- Latency, zero-wait slave: accept at edge E0, stb high in cycle 1, ack high in cycle 2, o_rsp_valid high in cycle 3, o_cmd_ready high in cycle 4. This gives 4 cycles per access back-to-back.
- Bus contention: the master never drives io_wb_data outside STB with we = 1.
- i_cmd_* is sampled only on accept. Changes while busy have no effect.
- Address is passed unmodified. Out-of-range decoding is the slave's job; a missing ack ends in timeout.

Test Plan:
- Read memory defaults: read addr 0, then 1, then 50 -> rsp_rdata 1, 262144, 500; err = 0; each rsp_valid exactly one cycle; rsp_valid 3 cycles after accept.
- Write then read: write addr 7 data 0xDEADBEEF, then read addr 7 -> write rsp rdata = 0; read returns 0xDEADBEEF. Master drives io_wb_data only during the write STB cycle. Bench checks no X on the bus.
- Back-to-back: hold i_cmd_valid high for 3 reads -> accepts 4 cycles apart, exactly 3 rsp_valid pulses. Slave's repeated ack in HOLD produces no extra response.
- Timeout: address 32'h0001_0000, slave never acks, TIMEOUT = 16 -> rsp_valid with err = 1 and rdata = 0 exactly 16 stb cycles after stb rises; cyc low next cycle.
- Ack racing timeout: stub slave acks on the same edge the counter reaches TIMEOUT-1 -> err = 0, data captured.
- Async reset in STB: drop rst mid-write -> cyc, stb and we go 0 and bus goes Z without a clock edge; no rsp_valid; after release, a read of addr 0 returns 1.
